// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and width helper for the buffered UART transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational head word; push and pop each take effect at the clock edge.
// Pushes while full and pops while empty are ignored, so the caller owns overflow reporting.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes a full FIFO from an empty one.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, self-timed baud, LSB-first frames sent back to back.
// A write into an empty idle FIFO starts the start bit one edge later; writes while full are dropped and flagged.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DIV        = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rw,
    input  logic [DATA_BITS-1:0] din,
    output logic                 busy,
    output logic                 full,
    output logic                 overflow,
    output logic                 done,
    output logic                 tx
);

    localparam int             CW        = clog2(DIV);
    localparam int             BW        = clog2(DATA_BITS);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_PRE   = CW'(DIV - 2);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic           ODD_INV   = (PARITY == PAR_ODD);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 done_q;
    logic                 ovf_q;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign stop_end = (state_q == ST_STOP) && bit_end && (stop_idx_q == STOP_LAST);
    assign push     = rw && !fifo_full;
    assign pop      = ((state_q == ST_IDLE) || stop_end) && !fifo_empty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= rw && fifo_full;
            // Registered one cycle early so the pulse lands on the final stop cycle.
            done_q <= (state_q == ST_STOP) && (stop_idx_q == STOP_LAST) && (cnt_q == CNT_PRE);

            if (state_q == ST_IDLE || bit_end) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        par_q   <= (^fifo_dout) ^ ODD_INV;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q != BIT_LAST) begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end else if (PARITY != PAR_NONE) begin
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
                        end else begin
                            tx_q       <= 1'b1;
                            stop_idx_q <= 1'b0;
                            state_q    <= ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_q       <= 1'b1;
                        stop_idx_q <= 1'b0;
                        state_q    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_idx_q != STOP_LAST) begin
                            stop_idx_q <= 1'b1;
                        end else if (!fifo_empty) begin
                            shift_q <= fifo_dout;
                            par_q   <= (^fifo_dout) ^ ODD_INV;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign full     = fifo_full;
    assign overflow = ovf_q;
    assign done     = done_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four DIV=4 instances (8N1, 8E1, 8O1, 7N2) driven from a vector table.
module tb_uart_tx_fifo;

    logic       clk_in;
    logic       rst;
    logic [3:0] rw;
    logic [7:0] din;
    logic [3:0] busy;
    logic [3:0] full;
    logic [3:0] ovf;
    logic [3:0] done;
    logic [3:0] tx;

    int n_vec;
    int n_miss;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [15:0] lv;    // tx level per bit period, bit 0 = start bit
        int          nlev;
    } vec_t;

    vec_t tbl [6];

    uart_tx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk_in(clk_in), .rst(rst), .rw(rw[0]), .din(din),
        .busy(busy[0]), .full(full[0]), .overflow(ovf[0]), .done(done[0]), .tx(tx[0]));

    uart_tx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk_in(clk_in), .rst(rst), .rw(rw[1]), .din(din),
        .busy(busy[1]), .full(full[1]), .overflow(ovf[1]), .done(done[1]), .tx(tx[1]));

    uart_tx_fifo #(.DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk_in(clk_in), .rst(rst), .rw(rw[2]), .din(din),
        .busy(busy[2]), .full(full[2]), .overflow(ovf[2]), .done(done[2]), .tx(tx[2]));

    uart_tx_fifo #(.DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk_in(clk_in), .rst(rst), .rw(rw[3]), .din(din[6:0]),
        .busy(busy[3]), .full(full[3]), .overflow(ovf[3]), .done(done[3]), .tx(tx[3]));

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Entered just after the start-bit edge; checks each bit mid-period, done placement and busy release.
    task automatic check_stream(input int sel, input logic [63:0] e, input int nlev, input int fc);
        int ndone;
        int bad_done;
        ndone    = 0;
        bad_done = 0;
        for (int c = 0; c < nlev * 4; c++) begin
            if (c % 4 == 2) chk1("tx_bit", tx[sel], e[c / 4]);
            if (done[sel]) ndone++;
            if (done[sel] !== ((c + 1) % fc == 0)) bad_done++;
            @(posedge clk_in); #1;
        end
        chkn("done_count", ndone, (nlev * 4) / fc);
        chkn("done_misplaced", bad_done, 0);
        chk1("busy_after_frame", busy[sel], 1'b0);
        chk1("tx_idle_after", tx[sel], 1'b1);
    endtask

    task automatic send_one(input int sel, input logic [7:0] data, input logic [63:0] e, input int nlev);
        rw[sel] = 1'b1;
        din     = data;
        @(posedge clk_in); #1;
        rw[sel] = 1'b0;
        chk1("busy_rise", busy[sel], 1'b1);
        chk1("tx_before_start", tx[sel], 1'b1);
        @(posedge clk_in); #1;
        chk1("start_latency", tx[sel], 1'b0);
        check_stream(sel, e, nlev, nlev * 4);
    endtask

    initial begin
        logic [63:0] e5;
        int          ndone;
        int          nlow;

        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        rw     = '0;
        din    = '0;

        tbl[0] = '{sel: 0, data: 8'h55, lv: 16'h02AA, nlev: 10};
        tbl[1] = '{sel: 1, data: 8'hF7, lv: 16'h07EE, nlev: 11};
        tbl[2] = '{sel: 2, data: 8'hF7, lv: 16'h05EE, nlev: 11};
        tbl[3] = '{sel: 3, data: 8'h7F, lv: 16'h03FE, nlev: 10};
        tbl[4] = '{sel: 0, data: 8'h00, lv: 16'h0200, nlev: 10};
        tbl[5] = '{sel: 1, data: 8'hA3, lv: 16'h0546, nlev: 11};

        repeat (3) @(posedge clk_in);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk1("reset_tx", tx[i], 1'b1);
            chk1("reset_busy", busy[i], 1'b0);
            chk1("reset_done", done[i], 1'b0);
            chk1("reset_full", full[i], 1'b0);
            chk1("reset_ovf", ovf[i], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk_in); #1;

        for (int i = 0; i < 6; i++) begin
            send_one(tbl[i].sel, tbl[i].data, {48'd0, tbl[i].lv}, tbl[i].nlev);
            repeat (2) @(posedge clk_in);
            #1;
        end

        // Two words on consecutive edges: the second frame follows the first stop bit directly.
        rw[0] = 1'b1;
        din   = 8'h55;
        @(posedge clk_in); #1;
        din = 8'hF7;
        @(posedge clk_in); #1;
        rw[0] = 1'b0;
        chk1("b2b_start", tx[0], 1'b0);
        check_stream(0, (64'h3EE << 10) | 64'h2AA, 20, 40);
        repeat (2) @(posedge clk_in);
        #1;

        // rw held for six cycles with words 1..6 while idle.
        e5 = '0;
        for (int i = 0; i < 5; i++) e5[10 * i +: 10] = {1'b1, 8'(i + 1), 1'b0};
        rw[0] = 1'b1;
        din   = 8'd1;
        @(posedge clk_in); #1;
        din = 8'd2;
        chk1("burst_busy", busy[0], 1'b1);
        @(posedge clk_in); #1;
        fork
            check_stream(0, e5, 50, 40);
            begin
                for (int c = 0; c < 6; c++) begin
                    if (c <= 3) din = 8'(c + 3);
                    else        rw[0] = 1'b0;
                    if (c == 2) chk1("full_at_3", full[0], 1'b0);
                    if (c == 3) chk1("full_at_5", full[0], 1'b1);
                    if (c == 4) chk1("ovf_pulse", ovf[0], 1'b1);
                    if (c == 5) chk1("ovf_clear", ovf[0], 1'b0);
                    @(posedge clk_in); #1;
                end
            end
        join
        repeat (2) @(posedge clk_in);
        #1;

        // Fill the FIFO, then reset in the middle of data bit 2 of the first frame.
        rw[0] = 1'b1;
        din   = 8'h55;
        @(posedge clk_in); #1;
        din = 8'h11;
        @(posedge clk_in); #1;
        din = 8'h22;
        @(posedge clk_in); #1;
        din = 8'h33;
        @(posedge clk_in); #1;
        din = 8'h44;
        @(posedge clk_in); #1;
        rw[0] = 1'b0;
        chk1("full_before_rst", full[0], 1'b1);
        repeat (10) @(posedge clk_in);
        #1;
        rst = 1'b1;
        @(posedge clk_in); #1;
        rst = 1'b0;
        chk1("rst_tx", tx[0], 1'b1);
        chk1("rst_busy", busy[0], 1'b0);
        chk1("rst_full", full[0], 1'b0);
        chk1("rst_done", done[0], 1'b0);
        ndone = 0;
        nlow  = 0;
        for (int c = 0; c < 60; c++) begin
            if (done[0]) ndone++;
            if (!tx[0]) nlow++;
            @(posedge clk_in); #1;
        end
        chkn("rst_no_done", ndone, 0);
        chkn("rst_line_quiet", nlow, 0);
        send_one(0, 8'h0F, 64'h21E, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
